count_dispatcher: RTL and testbench

Command dispatcher that sits directly upstream of the `fsm_counter` stage. It buffers count commands from a valid/ready producer in a small FIFO and launches one counter job at a time: a one-cycle `run` pulse with `in_count` held stable. It then waits for the counter's `done` pulse before launching the next job, and keeps a completed-job tally plus error flags.

---
 rtl/count_dispatcher.sv | 146 ++++++++++++++
 tb/tb_count_dispatcher.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/count_dispatcher.sv
// Buffers count commands in a small FIFO and launches them one at a time to a downstream counter.
// Optional WAIT-state watchdog is compiled in when DISPATCH_TIMEOUT_EN is defined.
module count_dispatcher #(
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [31:0]                cmd_count,
    output logic                       run,
    output logic [31:0]                in_count,
    input  logic                       done,
    output logic                       busy,
    output logic [$clog2(DEPTH):0]     fifo_level,
    output logic [15:0]                jobs_done,
    output logic                       zero_err,
    output logic                       timeout_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT
    } state_t;

    state_t state, state_next;
    logic   run_next, busy_next;

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;

    logic accept, push, pop, job_complete;

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 2) begin : g_bad_param
            $error("count_dispatcher: DEPTH must be a power of two >= 2, TIMEOUT_CYCLES >= 2");
        end
    endgenerate

    assign cmd_ready    = (fifo_level != LW'(DEPTH));
    assign accept       = cmd_valid && cmd_ready;
    // Zero counts finish the handshake but never reach the FIFO.
    assign push         = accept && (cmd_count != '0);
    assign pop          = (state == IDLE) && (fifo_level != '0);
    assign job_complete = (state == WAIT) && done;

`ifdef DISPATCH_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    logic [TW-1:0] timer;
    logic          timeout_hit;

    assign timeout_hit = (state == WAIT) && !done && (timer == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            timer       <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (state == LAUNCH) begin
                timer <= '0;
            end else if (state == WAIT && !done) begin
                timer <= timer + TW'(1);
            end
            if (timeout_hit) begin
                timeout_err <= 1'b1;
            end
        end
    end
`else
    logic timeout_hit;
    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                fifo_level <= fifo_level + LW'(1);
            end else if (pop && !push) begin
                fifo_level <= fifo_level - LW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= cmd_count;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            run       <= 1'b0;
            busy      <= 1'b0;
            in_count  <= '0;
            jobs_done <= '0;
            zero_err  <= 1'b0;
        end else begin
            state <= state_next;
            run   <= run_next;
            busy  <= busy_next;
            if (pop) begin
                in_count <= mem[rd_ptr];
            end
            if (job_complete) begin
                jobs_done <= jobs_done + 16'd1;
            end
            if (accept && cmd_count == '0) begin
                zero_err <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (fifo_level != '0) state_next = LAUNCH;
            LAUNCH:  state_next = WAIT;
            WAIT:    if (done || timeout_hit) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs are registered, so they are decoded from the upcoming state.
    always_comb begin
        run_next  = (state_next == LAUNCH);
        busy_next = (state_next != IDLE);
    end

endmodule

// File: tb/tb_count_dispatcher.sv
// Scoreboard bench for count_dispatcher with a behavioural model of the downstream counter.
module tb_count_dispatcher;

    localparam int DEPTH = 4;
`ifdef DISPATCH_TIMEOUT_EN
    localparam int TMO       = 16;
    localparam int MID_COUNT = 12;
    localparam int MID_WAIT  = 10;
`else
    localparam int TMO       = 1024;
    localparam int MID_COUNT = 100;
    localparam int MID_WAIT  = 20;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_count = '0;
    logic        run;
    logic [31:0] in_count;
    logic        done;
    logic        busy;
    logic [2:0]  fifo_level;
    logic [15:0] jobs_done;
    logic        zero_err;
    logic        timeout_err;

    count_dispatcher #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_count(cmd_count), .run(run), .in_count(in_count), .done(done),
        .busy(busy), .fifo_level(fifo_level), .jobs_done(jobs_done),
        .zero_err(zero_err), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Downstream counter: samples run, counts N cycles in RUN, one DONE cycle.
    typedef enum logic [1:0] {C_IDLE, C_RUN, C_DONE} cst_t;
    cst_t        cst;
    logic [31:0] rem;
    logic        force_done_low = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            cst <= C_IDLE;
            rem <= '0;
        end else begin
            case (cst)
                C_IDLE: if (run) begin rem <= in_count; cst <= C_RUN; end
                C_RUN:  if (rem <= 1) cst <= C_DONE; else rem <= rem - 1;
                default: cst <= C_IDLE;
            endcase
        end
    end
    assign done = (cst == C_DONE) && !force_done_low;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] exp_q[$];
    int unsigned exp_jobs = 0;
    int unsigned n_runs   = 0;
    int unsigned run_cyc  = 0;
    int unsigned done_gap = 0;
    logic [31:0] launched = '0;
    logic        prev_run = 1'b0;
    logic        saw_full = 1'b0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (run) begin
                check_eq("run_one_cycle", prev_run, 0);
                check_eq("run_counter_idle", cst == C_IDLE, 1);
                if (exp_q.size() == 0) check_eq("run_unexpected", 1, 0);
                else check_eq("run_in_count", in_count, exp_q.pop_front());
                launched = in_count;
                run_cyc  = cyc;
                n_runs++;
            end
            if (busy && !run) check_eq("in_count_hold", in_count, launched);
            if (done) begin
                exp_jobs++;
                done_gap = cyc - run_cyc;
            end
            if (fifo_level == 3'(DEPTH)) begin
                saw_full = 1'b1;
                check_eq("full_ready_low", cmd_ready, 0);
            end
            prev_run = run;
        end else begin
            prev_run = 1'b0;
        end
    end

    // Called and returns at a negedge; holds cmd_valid until the handshake edge.
    task automatic push(input logic [31:0] c);
        int unsigned n = 0;
        cmd_valid = 1'b1;
        cmd_count = c;
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check_eq("push_ready_timeout", n, 0);
        if (c != 0) exp_q.push_back(c);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_count = '0;
    endtask

    task automatic wait_idle(input int unsigned limit);
        int unsigned n = 0;
        while (!(busy == 1'b0 && fifo_level == '0 && exp_q.size() == 0) && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (n >= limit) check_eq("wait_idle_timeout", n, 0);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        exp_jobs = 0;
        saw_full = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_ready"}, cmd_ready, 1);
        check_eq({tag, "_level"}, fifo_level, 0);
        check_eq({tag, "_run"}, run, 0);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_jobs"}, jobs_done, 0);
        check_eq({tag, "_in_count"}, in_count, 0);
        check_eq({tag, "_zero_err"}, zero_err, 0);
        check_eq({tag, "_timeout_err"}, timeout_err, 0);
    endtask

    initial begin
        int unsigned runs0;
        int unsigned n;

        // Reset then idle
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_state("rst");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_state("idle");

        // Single job, count 5
        push(5);
        check_eq("single_level", fifo_level, 1);
        @(negedge clk);
        check_eq("single_run_hi", run, 1);
        check_eq("single_in_count", in_count, 5);
        check_eq("single_busy", busy, 1);
        @(negedge clk);
        check_eq("single_run_lo", run, 0);
        wait_idle(100);
        check_eq("single_done_gap", done_gap, 6);
        check_eq("single_jobs", jobs_done, 1);
        check_eq("single_jobs_model", jobs_done, 16'(exp_jobs));
        check_eq("single_in_count_after", in_count, 5);

        // Fill and drain
        do_reset();
        runs0 = n_runs;
        push(3); push(1); push(4); push(1); push(5); push(9);
        wait_idle(500);
        check_eq("fill_saw_full", saw_full, 1);
        check_eq("fill_runs", n_runs - runs0, 6);
        check_eq("fill_jobs", jobs_done, 6);
        check_eq("fill_zero_err", zero_err, 0);

        // Zero count is dropped
        do_reset();
        runs0 = n_runs;
        push(0);
        check_eq("zero_level", fifo_level, 0);
        check_eq("zero_err_set", zero_err, 1);
        push(2);
        wait_idle(100);
        check_eq("zero_runs", n_runs - runs0, 1);
        check_eq("zero_in_count", in_count, 2);
        check_eq("zero_jobs", jobs_done, 1);
        check_eq("zero_err_sticky", zero_err, 1);

        // Reset mid-job
        do_reset();
        push(MID_COUNT);
        repeat (MID_WAIT - 1) @(negedge clk);
        check_eq("mid_busy", busy, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_state("mid_rst");
        rst_n = 1'b1;
        exp_q.delete();
        exp_jobs = 0;
        @(negedge clk);
        push(2);
        wait_idle(100);
        check_eq("mid_after_jobs", jobs_done, 1);
        check_eq("mid_after_in_count", in_count, 2);

`ifdef DISPATCH_TIMEOUT_EN
        // Watchdog with done suppressed
        do_reset();
        force_done_low = 1'b1;
        push(7);
        @(negedge clk);
        check_eq("tmo_run", run, 1);
        n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("tmo_busy_cycles", n, 17);
        check_eq("tmo_err", timeout_err, 1);
        check_eq("tmo_jobs", jobs_done, 0);
        force_done_low = 1'b0;
        do_reset();
        check_eq("tmo_err_cleared", timeout_err, 0);
`else
        n = 0;
        check_eq("no_tmo_err", timeout_err, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
